// File: rtl/motion_pkg.sv
// Shared motion-control definitions for the drawing robot's stepper path.
package motion_pkg;

    localparam int unsigned DX_W                 = 16;
    localparam int unsigned DEFAULT_PULSE_CYCLES = 10;
    localparam logic        DIR_POS              = 1'b1;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSetup = 3'd1,
        StPulse = 3'd2,
        StGap   = 3'd3,
        StDone  = 3'd4
    } motion_state_e;

endpackage

// File: rtl/step_interval_timer.sv
// Cycle counter for one step period: the pulse window followed by the gap.
module step_interval_timer
    import motion_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = DEFAULT_PULSE_CYCLES,
    parameter int unsigned PER_W        = 24
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             start,
    input  logic [PER_W-1:0] eff_period,
    output logic             pulse_phase,
    output logic             period_end
);

    localparam logic [PER_W-1:0] PULSE_LAST = PER_W'(PULSE_CYCLES - 1);

    logic [PER_W-1:0] cnt_q;

    // cnt_q is the index of the current cycle within the period; start marks index 0.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // High while the following cycle still belongs to the pulse window.
    assign pulse_phase = (cnt_q < PULSE_LAST);
    assign period_end  = (cnt_q == eff_period - 1'b1);

endmodule

// File: rtl/stepper_line_controller.sv
// Two-axis Bresenham line sequencer: accepts one move, emits step/dir pulses,
// and tracks absolute position.
module stepper_line_controller
    import motion_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = DEFAULT_PULSE_CYCLES,
    parameter int unsigned PER_W        = 24,
    parameter int unsigned POS_W        = 32
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [DX_W-1:0]  cmd_dx,
    input  logic [DX_W-1:0]  cmd_dy,
    input  logic [PER_W-1:0] cmd_period,
    input  logic             abort,
    output logic             step_x,
    output logic             step_y,
    output logic             dir_x,
    output logic             dir_y,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y
);

    localparam int unsigned      ERR_W      = DX_W + 2;
    localparam logic [PER_W-1:0] MIN_PERIOD = PER_W'(2 * PULSE_CYCLES);

    motion_state_e state_q, state_d;

    logic [DX_W-1:0]  dx_q, dy_q;
    logic [PER_W-1:0] period_q;
    logic [DX_W-1:0]  steps_left_q, steps_left_d;
    logic signed [ERR_W-1:0] err_q, err_d, err_init, err_src, err_sub, err_step;

    logic [DX_W-1:0]  ax, ay, n_len, m_len;
    logic [PER_W-1:0] eff_period;
    logic             major_x, minor_step, dir_x_c, dir_y_c;
    logic             enter_pulse, pulse_phase, period_end;
    logic             step_x_d, step_y_d, dir_x_d, dir_y_d, aborted_d;
    logic [POS_W-1:0] pos_x_d, pos_y_d;

    // Geometry is derived from the held command, which stays stable for the whole move.
    assign ax         = dx_q[DX_W-1] ? (~dx_q + 1'b1) : dx_q;
    assign ay         = dy_q[DX_W-1] ? (~dy_q + 1'b1) : dy_q;
    assign major_x    = (ax >= ay);
    assign n_len      = major_x ? ax : ay;
    assign m_len      = major_x ? ay : ax;
    assign dir_x_c    = dx_q[DX_W-1] ? ~DIR_POS : DIR_POS;
    assign dir_y_c    = dy_q[DX_W-1] ? ~DIR_POS : DIR_POS;
    assign eff_period = (period_q < MIN_PERIOD) ? MIN_PERIOD : period_q;

    assign err_init   = $signed({2'b00, n_len >> 1});
    assign err_src    = (state_q == StSetup) ? err_init : err_q;
    assign err_sub    = err_src - $signed({2'b00, m_len});
    assign minor_step = err_sub[ERR_W-1];
    assign err_step   = minor_step ? (err_sub + $signed({2'b00, n_len})) : err_sub;

    step_interval_timer #(
        .PULSE_CYCLES (PULSE_CYCLES),
        .PER_W        (PER_W)
    ) u_timer (
        .clock_in    (clock_in),
        .reset_n     (reset_n),
        .start       (enter_pulse),
        .eff_period  (eff_period),
        .pulse_phase (pulse_phase),
        .period_end  (period_end)
    );

    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        steps_left_d = steps_left_q;
        step_x_d     = step_x;
        step_y_d     = step_y;
        dir_x_d      = dir_x;
        dir_y_d      = dir_y;
        pos_x_d      = pos_x;
        pos_y_d      = pos_y;
        aborted_d    = 1'b0;
        enter_pulse  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) state_d = StSetup;
            end
            StSetup: begin
                dir_x_d      = dir_x_c;
                dir_y_d      = dir_y_c;
                err_d        = err_init;
                steps_left_d = n_len;
                if (abort) begin
                    state_d   = StDone;
                    aborted_d = 1'b1;
                end else if (n_len == '0) begin
                    state_d = StDone;
                end else begin
                    enter_pulse = 1'b1;
                end
            end
            StPulse: begin
                if (abort) begin
                    state_d   = StDone;
                    aborted_d = 1'b1;
                end else if (!pulse_phase) begin
                    state_d      = StGap;
                    steps_left_d = steps_left_q - 1'b1;
                end
            end
            StGap: begin
                if (abort) begin
                    state_d   = StDone;
                    aborted_d = 1'b1;
                end else if (period_end) begin
                    if (steps_left_q != '0) enter_pulse = 1'b1;
                    else                    state_d     = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Each pulse entry is one Bresenham iteration: major axis always steps.
        if (enter_pulse) begin
            state_d  = StPulse;
            err_d    = err_step;
            step_x_d = major_x | minor_step;
            step_y_d = ~major_x | minor_step;
            if (step_x_d) begin
                pos_x_d = pos_x + ((dir_x_c == DIR_POS) ? POS_W'(1) : {POS_W{1'b1}});
            end
            if (step_y_d) begin
                pos_y_d = pos_y + ((dir_y_c == DIR_POS) ? POS_W'(1) : {POS_W{1'b1}});
            end
        end

        if (state_d != StPulse) begin
            step_x_d = 1'b0;
            step_y_d = 1'b0;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            dx_q         <= '0;
            dy_q         <= '0;
            period_q     <= '0;
            err_q        <= '0;
            steps_left_q <= '0;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            step_x       <= 1'b0;
            step_y       <= 1'b0;
            dir_x        <= 1'b0;
            dir_y        <= 1'b0;
            pos_x        <= '0;
            pos_y        <= '0;
        end else begin
            if (state_q == StIdle && cmd_valid) begin
                dx_q     <= cmd_dx;
                dy_q     <= cmd_dy;
                period_q <= cmd_period;
            end
            state_q      <= state_d;
            err_q        <= err_d;
            steps_left_q <= steps_left_d;
            cmd_ready    <= (state_d == StIdle);
            busy         <= (state_d != StIdle);
            done         <= (state_d == StDone);
            aborted      <= aborted_d;
            step_x       <= step_x_d;
            step_y       <= step_y_d;
            dir_x        <= dir_x_d;
            dir_y        <= dir_y_d;
            pos_x        <= pos_x_d;
            pos_y        <= pos_y_d;
        end
    end

endmodule

// File: tb/tb_stepper_line_controller.sv
// Directed bench for stepper_line_controller: step timing, Bresenham pattern,
// clamping, abort, back-pressure and asynchronous reset.
module tb_stepper_line_controller;

    logic        clock_in = 1'b0;
    logic        reset_n  = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_dx = '0;
    logic [15:0] cmd_dy = '0;
    logic [23:0] cmd_period = '0;
    logic        abort = 1'b0;
    logic        step_x, step_y, dir_x, dir_y, busy, done, aborted;
    logic [31:0] pos_x, pos_y;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    logic sx_prev = 1'b0;
    logic sy_prev = 1'b0;
    int rx[$];
    int fx[$];
    int ry[$];

    stepper_line_controller #(
        .PULSE_CYCLES (10),
        .PER_W        (24),
        .POS_W        (32)
    ) dut (
        .clock_in   (clock_in),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dx     (cmd_dx),
        .cmd_dy     (cmd_dy),
        .cmd_period (cmd_period),
        .abort      (abort),
        .step_x     (step_x),
        .step_y     (step_y),
        .dir_x      (dir_x),
        .dir_y      (dir_y),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .pos_x      (pos_x),
        .pos_y      (pos_y)
    );

    always #5 clock_in = ~clock_in;

    always @(posedge clock_in) cyc <= cyc + 1;

    always @(negedge clock_in) begin
        if (step_x && !sx_prev) rx.push_back(cyc);
        if (!step_x && sx_prev) fx.push_back(cyc);
        if (step_y && !sy_prev) ry.push_back(cyc);
        if (done) done_cnt <= done_cnt + 1;
        sx_prev <= step_x;
        sy_prev <= step_y;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock_in);
        #1 reset_n = 1'b1;
    endtask

    // t0 is the cycle in which cmd_valid and cmd_ready are both seen high.
    task automatic issue(input int dx, input int dy, input int per, input bit hold,
                         output int t0);
        @(posedge clock_in);
        #1;
        rx.delete();
        fx.delete();
        ry.delete();
        cmd_dx     = 16'(dx);
        cmd_dy     = 16'(dy);
        cmd_period = 24'(per);
        cmd_valid  = 1'b1;
        t0 = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock_in);
            if (cmd_ready) begin
                t0 = cyc;
                break;
            end
        end
        check("accept", longint'(t0 >= 0), 1);
        @(posedge clock_in);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int td, output int busy_n);
        td = -1;
        busy_n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock_in);
            if (busy) busy_n++;
            if (done) begin
                td = cyc;
                break;
            end
        end
    endtask

    int t0, t1, td, bn, d0;

    initial begin
        do_reset();
        @(negedge clock_in);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_step", {step_x, step_y}, 0);
        check("rst_pos", {pos_x, pos_y}, 0);

        // Straight X move: four pulses, 30-cycle spacing, 10 cycles wide.
        issue(4, 0, 30, 1'b0, t0);
        wait_done(td, bn);
        check("x4_done_t", td - t0, 122);
        check("x4_nrise", rx.size(), 4);
        check("x4_rise0", rx[0] - t0, 2);
        check("x4_rise1", rx[1] - t0, 32);
        check("x4_rise2", rx[2] - t0, 62);
        check("x4_rise3", rx[3] - t0, 92);
        check("x4_width", fx[0] - rx[0], 10);
        check("x4_ny", ry.size(), 0);
        check("x4_pos", $signed(pos_x), 4);
        check("x4_dir", dir_x, 1);
        check("x4_aborted", aborted, 0);

        // Diagonal with minor steps on periods 1 and 3.
        do_reset();
        issue(3, -2, 40, 1'b0, t0);
        wait_done(td, bn);
        check("d_done_t", td - t0, 122);
        check("d_nx", rx.size(), 3);
        check("d_rx2", rx[2] - t0, 82);
        check("d_ny", ry.size(), 2);
        check("d_ry0", ry[0] - t0, 2);
        check("d_ry1", ry[1] - t0, 82);
        check("d_dir_y", dir_y, 0);
        check("d_pos_x", $signed(pos_x), 3);
        check("d_pos_y", $signed(pos_y), -2);

        // Zero-length move.
        issue(0, 0, 30, 1'b0, t0);
        wait_done(td, bn);
        check("z_done_t", td - t0, 2);
        check("z_busy_n", bn, 2);
        check("z_aborted", aborted, 0);
        check("z_nrise", rx.size() + ry.size(), 0);

        // Period below the minimum is clamped to 2*PULSE_CYCLES.
        do_reset();
        issue(2, 0, 5, 1'b0, t0);
        wait_done(td, bn);
        check("c_nrise", rx.size(), 2);
        check("c_rise1", rx[1] - t0, 22);
        check("c_done_t", td - t0, 42);

        // Abort during the second pulse of a negative move.
        do_reset();
        issue(-5, 0, 30, 1'b0, t0);
        while (cyc < t0 + 34) @(negedge clock_in);
        abort = 1'b1;
        @(posedge clock_in);
        #1 abort = 1'b0;
        wait_done(td, bn);
        check("a_done_t", td - t0, 35);
        check("a_aborted", aborted, 1);
        check("a_step", step_x, 0);
        check("a_pos", $signed(pos_x), -2);
        check("a_dir", dir_x, 0);

        // Second command held valid across a move.
        do_reset();
        issue(1, 0, 20, 1'b1, t0);
        cmd_dx = 16'd2;
        wait_done(td, bn);
        check("h_done_t", td - t0, 22);
        check("h_ready_at_done", cmd_ready, 0);
        @(negedge clock_in);
        check("h_ready_after", cmd_ready, 1);
        t1 = cyc;
        @(posedge clock_in);
        #1 cmd_valid = 1'b0;
        wait_done(td, bn);
        check("h2_done_t", td - t1, 42);
        check("h2_rise", rx[1] - t1, 2);
        check("h2_pos", $signed(pos_x), 3);

        // Asynchronous reset in the gap: state clears before any clock edge.
        do_reset();
        issue(3, 0, 30, 1'b0, t0);
        while (cyc < t0 + 20) @(negedge clock_in);
        check("r_pre_pos", $signed(pos_x), 1);
        check("r_pre_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("r_pos", {pos_x, pos_y}, 0);
        check("r_busy", busy, 0);
        check("r_ready", cmd_ready, 1);
        check("r_dir", dir_x, 0);
        d0 = done_cnt;
        repeat (3) @(posedge clock_in);
        #1 reset_n = 1'b1;
        repeat (60) @(negedge clock_in);
        check("r_no_done", done_cnt - d0, 0);

        // Asynchronous reset mid-pulse drops both step lines at once.
        issue(2, 2, 30, 1'b0, t0);
        while (cyc < t0 + 5) @(negedge clock_in);
        check("rp_high", {step_x, step_y}, 3);
        reset_n = 1'b0;
        #1;
        check("rp_low", {step_x, step_y}, 0);
        #10 reset_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stepper_line_controller.md
Name: stepper_line_controller

Overview:
Sequences a two-axis straight-line move for the drawing robot's X/Y steppers. Accepts one move command (signed dx, dy, step period) over a valid/ready handshake. Interpolates the line with integer Bresenham and emits fixed-width step pulses plus direction levels for both axes. Tracks absolute position and sits between the processor's motion MMIO registers and the stepper driver pins.

Parameters:
PULSE_CYCLES, 10, step-pulse high time in clock cycles (>=1)
PER_W, 24, width of the step-period field in cycles
POS_W, 32, width of the absolute position counters

Ports:
clock_in  in  1  system clock; all logic is on its posedge
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_dx  in  16  signed X displacement in steps
cmd_dy  in  16  signed Y displacement in steps
cmd_period  in  PER_W  cycles between successive major-axis steps
abort  in  1  synchronous move cancel
step_x  out  1  X step pulse
step_y  out  1  Y step pulse
dir_x  out  1  X direction; 1 = positive
dir_y  out  1  Y direction; 1 = positive
busy  out  1  move in progress
done  out  1  one-cycle move-complete strobe
aborted  out  1  qualifies done: move was cancelled
pos_x  out  POS_W  signed absolute X position
pos_y  out  POS_W  signed absolute Y position

Behaviour:
- Reset (async, reset_n=0): state IDLE. All 1-bit outputs are 0 except cmd_ready=1. pos_x=pos_y=0. Internal counters are cleared. A reset mid-move drops the step lines low immediately and abandons the move with no done strobe.
- States: IDLE, SETUP, PULSE, GAP, DONE. Every output is registered.
- IDLE: cmd_ready=1. Acceptance occurs on cmd_valid&cmd_ready at edge t0, which moves the state to SETUP. Commands are latched only at acceptance.
- SETUP (1 cycle):
  - Latch dir_x=(dx>=0) and dir_y=(dy>=0). Directions hold until the next SETUP.
  - ax=|dx| and ay=|dy| are 16-bit unsigned, so -32768 gives 32768.
  - n=max(ax,ay) and m=min(ax,ay). The major axis is X when ax>=ay.
  - err is 18-bit signed, initialised to n>>1. steps_left=n.
  - eff_period = max(cmd_period, 2*PULSE_CYCLES).
  - If n=0, go to DONE. Otherwise go to PULSE.
- PULSE (PULSE_CYCLES cycles):
  - On entry, compute e'=err-m. The minor axis steps this period iff e'<0; in that case err=e'+n, else err=e'.
  - The major-axis step line is high for the whole state. The minor-axis line is high only on its step periods.
  - On entry, pos of each stepping axis changes by ±1 per dir, with two's-complement wrap.
- GAP (eff_period-PULSE_CYCLES cycles): step lines are low and steps_left is decremented. When the gap expires, go to PULSE if steps_left>0, else DONE.
- DONE (1 cycle): done=1, then IDLE.
- busy=1 in every state except IDLE.
- Timing: the first step edge is high from t0+2. Successive rising edges are eff_period apart. done is asserted at t0+2+n*eff_period.
- abort=1 in SETUP, PULSE or GAP:
  - Next cycle: DONE with aborted=1 and step lines low. A truncated pulse is permitted.
  - pos reflects every pulse already started.
  - abort in IDLE or DONE is ignored.
- cmd_valid held while busy: not accepted. It is accepted at the first IDLE cycle after done.

Decomposition:
- Shared package motion_pkg:
  - State encoding constants.
  - DX_W=16.
  - Default PULSE_CYCLES.
  - Direction polarity constant DIR_POS=1.
- Sub-module step_interval_timer holds the PULSE/GAP cycle counter.
  - Inputs: start, eff_period, PULSE_CYCLES.
  - Outputs: pulse_phase, period_end tick.
- Bresenham and position logic stay in the top module.

Test Plan:
- PULSE_CYCLES=10, dx=4, dy=0, period=30, accept at t0 -> 4 step_x pulses rising at t0+2/32/62/92, each 10 cycles wide; step_y=0; done at t0+122; pos_x=4; dir_x=1.
- dx=3, dy=-2, period=40 -> step_x on all 3 periods, step_y on periods 1 and 3 only, dir_y=0, final pos=(3,-2), done at t0+122.
- dx=0, dy=0 -> no pulses, busy for 2 cycles, done at t0+2, aborted=0.
- period=5 -> clamped to 20; dx=2 gives rising edges at t0+2 and t0+22.
- Abort asserted during the second pulse of a dx=-5 move -> DONE next cycle, aborted=1, pos_x=-2.
- Second command held valid during a move -> cmd_ready=0 until the cycle after done, then accepted.
- reset_n pulsed mid-GAP -> outputs and pos cleared asynchronously, and no done is emitted.
